// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: line geometry constants/helpers and gather FSM states shared by the memory-response blocks
package gpu_mem_pkg;
    localparam int LINE_SHIFT_DEF = 6;
    localparam int LINE_BYTES = 1 << LINE_SHIFT_DEF;
    localparam int LINE_BITS = 8 * LINE_BYTES;
    localparam int WORD_OFF_W = LINE_SHIFT_DEF - 2;

    typedef enum logic [1:0] {IDLE, COLLECT, WB} state_t;

    function automatic int line_bits(input int shift);
        return 8 << shift;
    endfunction

    function automatic int word_off_w(input int shift);
        return shift - 2;
    endfunction
endpackage

// File: rtl/line_word_select.sv
// line_word_select: picks the 32-bit word at a word offset out of one cache line
module line_word_select
    import gpu_mem_pkg::*;
#(
    parameter int LINE_SHIFT = LINE_SHIFT_DEF
) (
    input  logic [line_bits(LINE_SHIFT)-1:0]  line,
    input  logic [word_off_w(LINE_SHIFT)-1:0] off,
    output logic [31:0]                       word
);
    assign word = line[32*off +: 32];
endmodule

// File: rtl/warp_resp_gather.sv
// warp_resp_gather: gathers per-lane 32-bit words from line responses into one warp writeback.
// Optional macro RESP_TIMEOUT_EN adds an idle-response abort after TIMEOUT_CYC cycles.
module warp_resp_gather
    import gpu_mem_pkg::*;
#(
    parameter int W           = 32,
    parameter int ADDR_W      = 64,
    parameter int LINE_SHIFT  = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_valid,
    output logic                             start_ready,
    input  logic [W-1:0]                     lane_valid,
    input  logic [W*ADDR_W-1:0]              lane_addrs_flat,
    input  logic                             resp_valid,
    output logic                             resp_ready,
    input  logic [W-1:0]                     resp_lane_mask,
    input  logic [line_bits(LINE_SHIFT)-1:0] resp_data,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [W*32-1:0]                  wb_data,
    output logic [W-1:0]                     wb_mask,
    output logic                             wb_err,
    output logic                             busy
);
    localparam int OW = word_off_w(LINE_SHIFT);

    state_t state, state_nxt;
    logic [W-1:0] pending, hit, stray;
    logic [W-1:0][OW-1:0] off;
    logic [W-1:0][31:0] word;
    logic start_fire, acc, tmo;
    logic unused_addr;

    assign start_fire = start_valid && state == IDLE;
    assign acc = resp_valid && state == COLLECT;
    assign hit = resp_lane_mask & pending;
    assign stray = resp_lane_mask & ~pending;
    assign unused_addr = ^lane_addrs_flat;

    genvar i;
    for (i = 0; i < W; i++) begin : g_sel
        line_word_select #(.LINE_SHIFT(LINE_SHIFT)) u_sel (
            .line(resp_data),
            .off (off[i]),
            .word(word[i])
        );
    end

`ifdef RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || state != COLLECT || acc) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
    assign tmo = state == COLLECT && !acc && cnt == CW'(TIMEOUT_CYC - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_ready = state == IDLE;
        resp_ready  = state == COLLECT;
        wb_valid    = state == WB;
        busy        = state != IDLE;
        case (state)
            IDLE:    state_nxt = start_valid ? (|lane_valid ? COLLECT : WB) : IDLE;
            COLLECT: state_nxt = (acc && (pending & ~hit) == '0) || tmo ? WB : COLLECT;
            WB:      state_nxt = wb_ready ? IDLE : WB;
            default: state_nxt = IDLE;
        endcase
    end

    // lanes outside pending never touch wb_data, so unfilled lanes keep the zero from start
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            off     <= '0;
            wb_data <= '0;
            wb_mask <= '0;
            wb_err  <= 1'b0;
        end else if (start_fire) begin
            pending <= lane_valid;
            wb_data <= '0;
            wb_mask <= '0;
            wb_err  <= 1'b0;
            for (int l = 0; l < W; l++) off[l] <= lane_addrs_flat[l*ADDR_W+2 +: OW];
        end else if (acc) begin
            pending <= pending & ~hit;
            wb_mask <= wb_mask | hit;
            wb_err  <= wb_err | (|stray);
            for (int l = 0; l < W; l++) if (hit[l]) wb_data[32*l +: 32] <= word[l];
        end else if (tmo) begin
            wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_warp_resp_gather.sv
// tb_warp_resp_gather: table-driven gather vectors plus empty-warp, busy-start and mid-collect reset sequences
module tb_warp_resp_gather;
    localparam int W = 32;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic rst, start_valid, start_ready, resp_valid, resp_ready;
    logic wb_valid, wb_ready, wb_err, busy;
    logic [W-1:0] lane_valid, resp_lane_mask, wb_mask;
    logic [W*AW-1:0] lane_addrs_flat;
    logic [511:0] resp_data;
    logic [W*32-1:0] wb_data;
    int checks = 0;
    int errors = 0;
    logic watch = 1'b0;
    logic wb_seen = 1'b0;

    always #5 clk = ~clk;

    warp_resp_gather dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .lane_valid(lane_valid), .lane_addrs_flat(lane_addrs_flat),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_lane_mask(resp_lane_mask),
        .resp_data(resp_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_mask(wb_mask), .wb_err(wb_err), .busy(busy)
    );

    always @(posedge clk) if (watch && wb_valid) wb_seen <= 1'b1;

    typedef struct {
        string       nm;
        logic [31:0] lv;
        logic [63:0] base;
        logic [63:0] stride;
        int          nres;
        logic [31:0] m0, m1;
        logic [63:0] l0, l1;
        logic [31:0] emask;
        logic        eerr;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [63:0] line, input int k);
        logic [15:0] lo;
        lo = line[15:0];
        return (line == 64'h2000 && k == 2) ? 32'hDEADBEEF : {lo ^ 16'h5A5A, 8'hA0, 8'(k)};
    endfunction

    function automatic logic [511:0] mkline(input logic [63:0] line);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[32*k +: 32] = pat(line, k);
        return d;
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] lv, input logic [63:0] base,
                                input logic [63:0] stride, input int nres,
                                input logic [31:0] m0, input logic [63:0] l0,
                                input logic [31:0] m1, input logic [63:0] l1,
                                input logic [31:0] emask, input logic eerr);
        vec_t v;
        v.nm = nm; v.lv = lv; v.base = base; v.stride = stride; v.nres = nres;
        v.m0 = m0; v.l0 = l0; v.m1 = m1; v.l1 = l1; v.emask = emask; v.eerr = eerr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] pend, mask;
        logic [63:0] a, line;
        logic [31:0] exp_d [W];
        pend = v.lv;
        for (int i = 0; i < W; i++) exp_d[i] = '0;
        @(negedge clk);
        chk({v.nm, "_start_ready"}, start_ready, 1);
        start_valid = 1'b1;
        lane_valid = v.lv;
        for (int i = 0; i < W; i++) lane_addrs_flat[i*AW +: AW] = v.base + v.stride * i;
        @(negedge clk);
        start_valid = 1'b0;
        chk({v.nm, "_resp_ready"}, resp_ready, 1);
        for (int r = 0; r < v.nres; r++) begin
            mask = r == 0 ? v.m0 : v.m1;
            line = r == 0 ? v.l0 : v.l1;
            resp_valid = 1'b1;
            resp_lane_mask = mask;
            resp_data = mkline(line);
            for (int i = 0; i < W; i++) begin
                a = v.base + v.stride * i;
                if (mask[i] && pend[i]) begin
                    exp_d[i] = pat(line, int'(a[5:2]));
                    pend[i] = 1'b0;
                end
            end
            @(negedge clk);
            resp_valid = 1'b0;
            if (r < v.nres - 1) chk({v.nm, "_wb_early"}, wb_valid, 0);
        end
        chk({v.nm, "_wb_valid"}, wb_valid, 1);
        chk({v.nm, "_wb_mask"}, wb_mask, v.emask);
        chk({v.nm, "_wb_err"}, wb_err, v.eerr);
        for (int i = 0; i < W; i++)
            chk($sformatf("%s_lane%0d", v.nm, i), wb_data[32*i +: 32], exp_d[i]);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk({v.nm, "_wb_done"}, wb_valid, 0);
        chk({v.nm, "_idle"}, start_ready, 1);
    endtask

    initial begin
        tbl[0] = mk("unit", 32'hFFFF_FFFF, 64'h1000, 4, 2, 32'h0000_FFFF, 64'h1000,
                    32'hFFFF_0000, 64'h1040, 32'hFFFF_FFFF, 1'b0);
        tbl[1] = mk("bcast", 32'hFFFF_FFFF, 64'h2008, 0, 1, 32'hFFFF_FFFF, 64'h2000,
                    32'h0, 64'h0, 32'hFFFF_FFFF, 1'b0);
        tbl[2] = mk("partial", 32'h0000_00F0, 64'h3000, 4, 1, 32'h0000_00FF, 64'h3000,
                    32'h0, 64'h0, 32'h0000_00F0, 1'b1);
        tbl[3] = mk("reorder", 32'hFFFF_FFFF, 64'h5000, 4, 2, 32'hFFFF_0000, 64'h5040,
                    32'hFFFF_FFFF, 64'h5000, 32'hFFFF_FFFF, 1'b1);
        tbl[4] = mk("lowbits", 32'h0000_000F, 64'h6003, 4, 1, 32'h0000_000F, 64'h6000,
                    32'h0, 64'h0, 32'h0000_000F, 1'b0);
        tbl[5] = mk("zeromask", 32'h0000_0001, 64'h7010, 4, 2, 32'h0, 64'h7000,
                    32'h0000_0001, 64'h7000, 32'h0000_0001, 1'b0);

        rst = 1'b1; start_valid = 1'b0; lane_valid = '0; lane_addrs_flat = '0;
        resp_valid = 1'b0; resp_lane_mask = '0; resp_data = '0; wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_mask", wb_mask, 0);
        chk("rst_wb_err", wb_err, 0);

        // empty warp: straight to WB, held while wb_ready is low, start ignored throughout
        start_valid = 1'b1;
        lane_valid = '0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("empty_wb_valid", wb_valid, 1);
            chk("empty_start_ready", start_ready, 0);
            chk("empty_wb_mask", wb_mask, 0);
            chk("empty_wb_err", wb_err, 0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("empty_after_wb_valid", wb_valid, 0);
        chk("empty_after_start_ready", start_ready, 1);
        start_valid = 1'b0;

        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // reset mid-collect after one of two responses, with a stray start while busy
        @(negedge clk);
        start_valid = 1'b1;
        lane_valid = '1;
        for (int i = 0; i < W; i++) lane_addrs_flat[i*AW +: AW] = 64'h1000 + 4 * i;
        @(negedge clk);
        start_valid = 1'b0;
        resp_valid = 1'b1;
        resp_lane_mask = 32'h0000_FFFF;
        resp_data = mkline(64'h1000);
        @(negedge clk);
        resp_valid = 1'b0;
        chk("mid_wb_valid", wb_valid, 0);
        chk("mid_busy", busy, 1);
        start_valid = 1'b1;
        lane_valid = '0;
        @(negedge clk);
        start_valid = 1'b0;
        chk("busy_start_ignored", resp_ready, 1);
        watch = 1'b1;
        rst = 1'b1;
        resp_valid = 1'b1;
        resp_lane_mask = 32'hFFFF_0000;
        resp_data = mkline(64'h1040);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resp_valid = 1'b0;
        chk("abort_start_ready", start_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_wb_mask", wb_mask, 0);
        chk("abort_lane0", wb_data[31:0], 0);
        repeat (3) @(negedge clk);
        watch = 1'b0;
        chk("abort_no_wb", wb_seen, 0);
        run_vec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
